// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared types and defaults for the circular-convolution datapath slice.
//   XLEN         : default bits per weight word
//   WIDTH        : default number of weights per coefficient vector
//   weight_vec_t : full coefficient vector, index 0 in the low word
//   wl_state_t   : weight_loader FSM states (kept here so benches can probe)
// ---------------------------------------------------------------------------
package cc_pkg;

   localparam int unsigned XLEN  = 16;
   localparam int unsigned WIDTH = 128;

   typedef logic [WIDTH-1:0][XLEN-1:0] weight_vec_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2
   } wl_state_t;

endpackage

// File: rtl/weight_loader_if.sv
// ---------------------------------------------------------------------------
// weight_loader_if
// Serial weight-word stream into weight_loader.
//   load_start : single-cycle request to begin a new vector (source -> sink)
//   load_valid : load_data valid this cycle (source -> sink)
//   load_data  : serial weight word, first accepted word is index 0
//   load_ready : sink accepts a word this cycle (sink -> source)
// Modports: master = word source, slave = weight_loader.
// ---------------------------------------------------------------------------
interface weight_loader_if #(
   parameter int unsigned XLEN = cc_pkg::XLEN
) ();

   logic            load_start;
   logic            load_valid;
   logic [XLEN-1:0] load_data;
   logic            load_ready;

   modport master (
      output load_start,
      output load_valid,
      output load_data,
      input  load_ready
   );

   modport slave (
      input  load_start,
      input  load_valid,
      input  load_data,
      output load_ready
   );

endinterface

// File: rtl/weight_loader.sv
// ---------------------------------------------------------------------------
// weight_loader
// Collects a WIDTH x XLEN coefficient vector from a serial word stream into a
// shadow bank, then commits the whole vector into the active bank in a single
// edge once the datapath reports that swapping is safe.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   ld            : serial load stream (slave side)
//   swap_allowed  : datapath idle, commit permitted this cycle
//   weights       : active bank, registered
//   weights_valid : a vector has been committed since reset
//   swap_done     : one-cycle pulse in the cycle after each commit
//   busy          : FSM not idle
//   overrun       : sticky, load_start seen while a load was in progress
// ---------------------------------------------------------------------------
module weight_loader #(
   parameter int unsigned XLEN  = cc_pkg::XLEN,
   parameter int unsigned WIDTH = cc_pkg::WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   weight_loader_if.slave              ld,
   input  logic                        swap_allowed,
   output logic [WIDTH-1:0][XLEN-1:0]  weights,
   output logic                        weights_valid,
   output logic                        swap_done,
   output logic                        busy,
   output logic                        overrun
);

   import cc_pkg::*;

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   wl_state_t                   state_q;
   wl_state_t                   state_d;
   logic [IDX_W-1:0]            idx_q;
   logic [WIDTH-1:0][XLEN-1:0]  shadow_q;
   logic [WIDTH-1:0][XLEN-1:0]  weights_q;

   logic accept_c;
   logic commit_c;
   logic clr_idx_c;
   logic overrun_set_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle control decode
   always_comb begin
      state_d       = state_q;
      accept_c      = 1'b0;
      commit_c      = 1'b0;
      clr_idx_c     = 1'b0;
      overrun_set_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld.load_start) begin
               state_d   = LOAD;
               clr_idx_c = 1'b1;
            end
         end
         LOAD: begin
            // A restart request never aborts the load, it is only flagged.
            overrun_set_c = ld.load_start;
            if (ld.load_valid) begin
               accept_c = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            overrun_set_c = ld.load_start;
            if (swap_allowed) begin
               commit_c = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Ready and busy are pure decodes of the state register
   assign ld.load_ready = (state_q == LOAD);
   assign busy          = (state_q != IDLE);

   // Index counter, shadow bank, active bank and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q         <= '0;
         shadow_q      <= '0;
         weights_q     <= '0;
         weights_valid <= 1'b0;
         swap_done     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         swap_done <= commit_c;
         // The counter parks on the last index instead of wrapping.
         if (clr_idx_c) begin
            idx_q <= '0;
         end else if (accept_c && (idx_q != LAST_IDX)) begin
            idx_q <= idx_q + IDX_W'(1);
         end
         if (accept_c) begin
            shadow_q[idx_q] <= ld.load_data;
         end
         // Whole-vector copy so the datapath never sees a partial update.
         if (commit_c) begin
            weights_q     <= shadow_q;
            weights_valid <= 1'b1;
         end
         if (overrun_set_c) begin
            overrun <= 1'b1;
         end
      end
   end

   assign weights = weights_q;

endmodule
